// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    // All segments dark (active-low bus).
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Hex digit to {g,f,e,d,c,b,a}, active-low; index 0 is the first entry.
    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern with blanking.
module hex7seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    // A blanked digit ignores its nibble entirely.
    assign seg_o = blank_i ? SEG_OFF : SEG_LUT[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller driving a 74x138 select.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NIB_W*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic [DIGITS-1:0]       blank_in,
    output logic [IDX_W-1:0]        sel_o,
    output logic                    g1_o,
    output logic [SEG_W-1:0]        seg_o,
    output logic                    dp_o,
    output logic                    frame_done
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    // Dead time must exist and must leave at least one lit cycle per slot.
    if (BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_bad_cfg
        $error("seg_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < CLK_HZ/SCAN_HZ");
    end

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      g1_q, g1_d;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      fd_q, fd_d;
    logic [NIB_W*DIGITS-1:0]   snap_data_q;
    logic [DIGITS-1:0]         snap_dp_q, snap_blank_q;
    logic                      snap_ld;

    logic [IDX_W-1:0]          idx_nxt_c;
    logic                      live_c;
    logic [NIB_W-1:0]          nib_c;
    logic                      dp_bit_c, blank_bit_c;
    logic [SEG_W-1:0]          dec_seg_c;
    logic                      dec_dp_c;

    // Digit about to be shown: digit 0 from live inputs at frame start, else from snapshot.
    assign idx_nxt_c   = idx_q + IDX_W'(1);
    assign live_c      = (state_q == IDLE) || (idx_q == IDX_LAST);
    assign nib_c       = live_c ? data_in[NIB_W-1:0] : snap_data_q[{idx_nxt_c, 2'b00} +: NIB_W];
    assign dp_bit_c    = live_c ? dp_in[0]    : snap_dp_q[idx_nxt_c];
    assign blank_bit_c = live_c ? blank_in[0] : snap_blank_q[idx_nxt_c];
    assign dec_dp_c    = ~dp_bit_c | blank_bit_c;

    hex7seg u_hex7seg (
        .nib_i   (nib_c),
        .blank_i (blank_bit_c),
        .seg_o   (dec_seg_c)
    );

    // Next-state and registered-output logic for the scan sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        g1_d    = g1_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        fd_d    = 1'b0;
        snap_ld = 1'b0;

        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            g1_d    = 1'b0;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    g1_d    = 1'b0;
                    seg_d   = dec_seg_c;
                    dp_d    = dec_dp_c;
                    snap_ld = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        g1_d    = 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_nxt_c;
                        g1_d    = 1'b0;
                        seg_d   = dec_seg_c;
                        dp_d    = dec_dp_c;
                        if (idx_q == IDX_LAST) begin
                            fd_d    = 1'b1;
                            snap_ld = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    g1_d    = 1'b0;
                    seg_d   = SEG_OFF;
                    dp_d    = 1'b1;
                end
            endcase
        end
    end

    // State, counters and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            g1_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            g1_q    <= g1_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    // Per-frame snapshot so a frame never mixes old and new digit data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
        end else if (snap_ld) begin
            snap_data_q  <= data_in;
            snap_dp_q    <= dp_in;
            snap_blank_q <= blank_in;
        end
    end

    assign sel_o      = idx_q;
    assign g1_o       = g1_q;
    assign seg_o      = seg_q;
    assign dp_o       = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a timeline-based reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned SLOT  = 8;
    localparam int unsigned FRAME = 64;
    localparam int unsigned BLNK  = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic [2:0]  sel_o;
    logic        g1_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(
        .CLK_HZ    (80),
        .SCAN_HZ   (10),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .sel_o      (sel_o),
        .g1_o       (g1_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table for hex digits 0..F (active-low {g..a}).
    logic [6:0] ref_lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: time t in cycles since the enabling edge, plus the frame's latched inputs.
    bit          act;
    int unsigned t;
    logic [31:0] s_data;
    logic [7:0]  s_dp, s_blank;
    int unsigned e_sel;
    int          fd_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d act=%0d)", tag, obs, exp, t, act);
        end
    endtask

    task automatic check_outputs();
        logic [6:0] e_seg;
        logic       e_dp, e_g1, e_fd;
        if (!act) begin
            e_sel = 0; e_g1 = 1'b0; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            e_sel = (t / SLOT) % 8;
            e_g1  = (t % SLOT) >= BLNK;
            e_fd  = (t % FRAME == 0) && (t != 0);
            if (s_blank[e_sel]) begin
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_seg = ref_lut[s_data[4*e_sel +: 4]];
                e_dp  = ~s_dp[e_sel];
            end
        end
        check("sel",        32'(sel_o),      32'(e_sel));
        check("g1",         32'(g1_o),       32'(e_g1));
        check("seg",        32'(seg_o),      32'(e_seg));
        check("dp",         32'(dp_o),       32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        if (frame_done) fd_count++;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (!rst_n || !en) begin
            act = 1'b0;
        end else if (!act) begin
            act = 1'b1; t = 0;
            s_data = data_in; s_dp = dp_in; s_blank = blank_in;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                s_data = data_in; s_dp = dp_in; s_blank = blank_in;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until digit `dig` is shown with slot phase in [lo,hi]; bounded.
    task automatic run_until(input string tag, input int dig, input int lo, input int hi);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (act && ((t / SLOT) % 8) == dig && (t % SLOT) >= lo && (t % SLOT) <= hi)
                found = 1'b1;
            else
                step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        act = 1'b0; t = 0; s_data = '0; s_dp = '0; s_blank = '0; fd_count = 0;
        rst_n = 1'b0; en = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;

        // Reset values while held in reset.
        run(3);
        #2 rst_n = 1'b1;

        // Scenario 1/2: counting pattern, two frames.
        data_in = 32'h76543210; en = 1'b1;
        fd_count = 0;
        run(2 * FRAME + 1);
        check("fd_per_two_frames", 32'(fd_count), 32'd2);

        // Scenario 3: change data mid-frame during digit 3.
        run_until("wait_digit3", 3, 0, 7);
        data_in = 32'hFFFFFFFF;
        run(FRAME);

        // Scenario 4: blank digit 2, decimal point on digit 0.
        data_in = 32'h89ABCDEF; blank_in = 8'h04; dp_in = 8'h01;
        run(2 * FRAME);

        // Scenario 5: drop enable during digit 5 SHOW, then restart.
        run_until("wait_digit5_show", 5, BLNK, SLOT - 1);
        en = 1'b0;
        fd_count = 0;
        step();
        check("abort_g1", 32'(g1_o), 32'd0);
        run(FRAME);
        check("abort_no_fd", 32'(fd_count), 32'd0);
        data_in = $urandom; dp_in = 8'($urandom); blank_in = 8'h00;
        en = 1'b1;
        run(FRAME + 4);

        // Scenario 6: asynchronous reset mid-BLANK, then replay scenario 1.
        run_until("wait_blank", 6, 0, 0);
        #2 rst_n = 1'b0;
        act = 1'b0;
        #1;
        check("async_sel",  32'(sel_o),      32'd0);
        check("async_g1",   32'(g1_o),       32'd0);
        check("async_seg",  32'(seg_o),      32'h7F);
        check("async_dp",   32'(dp_o),       32'd1);
        check("async_fd",   32'(frame_done), 32'd0);
        step();
        #3 rst_n = 1'b1;
        data_in = 32'h76543210; dp_in = 8'h00; blank_in = 8'h00;
        run(FRAME + 1);

        // Random traffic with occasional enable drops.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                data_in  = $urandom;
                dp_in    = 8'($urandom);
                blank_in = 8'($urandom) & 8'($urandom);
            end
            en = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
